// File: rtl/tournament_choice_table_if.sv
// Lookup/update bus of the tournament choice table. With TOURNAMENT_CHOICE_STATS_EN
// defined the bus also carries the global_wins/local_wins statistics counters.
interface tournament_choice_table_if #(
  parameter int unsigned IDX_W = 6
);
  logic             ready;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_index;
  logic             choice_valid;
  logic [1:0]       choice_prediction;
  logic             update_valid;
  logic [IDX_W-1:0] update_index;
  logic             global_correct;
  logic             local_correct;
`ifdef TOURNAMENT_CHOICE_STATS_EN
  logic [15:0]      global_wins;
  logic [15:0]      local_wins;
`endif

  modport master (
    input  ready, choice_valid, choice_prediction,
`ifdef TOURNAMENT_CHOICE_STATS_EN
    input  global_wins, local_wins,
`endif
    output lookup_valid, lookup_index, update_valid, update_index,
           global_correct, local_correct
  );

  modport slave (
    output ready, choice_valid, choice_prediction,
`ifdef TOURNAMENT_CHOICE_STATS_EN
    output global_wins, local_wins,
`endif
    input  lookup_valid, lookup_index, update_valid, update_index,
           global_correct, local_correct
  );
endinterface

// File: rtl/tournament_choice_table.sv
// Tournament predictor choice (meta) counter table: init sweep, registered lookup,
// saturating RMW update. Optional statistics via TOURNAMENT_CHOICE_STATS_EN.
module tournament_choice_table #(
  parameter int unsigned IDX_W      = 6,
  parameter logic [1:0]  INIT_VALUE = 2'b01
) (
  input logic                    clk,
  input logic                    reset_n,
  tournament_choice_table_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [1:0]       table_mem [DEPTH];
  logic             choice_valid_q;
  logic [1:0]       choice_pred_q;

  logic             upd_inc, upd_dec, upd_write;
  logic [1:0]       upd_old, upd_new, lk_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (ptr_q == '1) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ptr_q <= '0;
    else if (state_q == ST_INIT) ptr_q <= ptr_q + 1'b1;
  end

  always_comb begin
    upd_inc   = (state_q == ST_RUN) && bus.update_valid && bus.global_correct && !bus.local_correct;
    upd_dec   = (state_q == ST_RUN) && bus.update_valid && !bus.global_correct && bus.local_correct;
    upd_write = upd_inc || upd_dec;
    upd_old   = table_mem[bus.update_index];
    upd_new   = upd_old;
    if (upd_inc && upd_old != 2'b11) upd_new = upd_old + 2'b01;
    if (upd_dec && upd_old != 2'b00) upd_new = upd_old - 2'b01;
    // Write-first: a same-cycle update to the looked-up entry is forwarded.
    lk_data = table_mem[bus.lookup_index];
    if (upd_write && bus.update_index == bus.lookup_index) lk_data = upd_new;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) table_mem[ptr_q] <= INIT_VALUE;
    else if (upd_write)     table_mem[bus.update_index] <= upd_new;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      choice_valid_q <= 1'b0;
      choice_pred_q  <= 2'b00;
    end else if (state_q == ST_RUN) begin
      choice_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) choice_pred_q <= lk_data;
    end else begin
      choice_valid_q <= 1'b0;
    end
  end

  assign bus.ready             = (state_q == ST_RUN);
  assign bus.choice_valid      = choice_valid_q;
  assign bus.choice_prediction = choice_pred_q;

`ifdef TOURNAMENT_CHOICE_STATS_EN
  logic [15:0] global_wins_q, local_wins_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      global_wins_q <= '0;
      local_wins_q  <= '0;
    end else begin
      if (upd_inc && global_wins_q != 16'hFFFF) global_wins_q <= global_wins_q + 16'd1;
      if (upd_dec && local_wins_q  != 16'hFFFF) local_wins_q  <= local_wins_q + 16'd1;
    end
  end

  assign bus.global_wins = global_wins_q;
  assign bus.local_wins  = local_wins_q;
`endif
endmodule

// File: tb/tb_tournament_choice_table.sv
// Directed, table-driven bench for tournament_choice_table (IDX_W=6, INIT_VALUE=01).
module tb_tournament_choice_table;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tournament_choice_table_if #(.IDX_W(6)) bus ();

  tournament_choice_table #(.IDX_W(6), .INIT_VALUE(2'b01)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       upd_v;
    logic [5:0] upd_idx;
    logic       gc;
    logic       lc;
    logic       lk_v;
    logic [5:0] lk_idx;
    logic       exp_valid;
    logic [1:0] exp_pred;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.lookup_valid   = 1'b0;
    bus.lookup_index   = '0;
    bus.update_valid   = 1'b0;
    bus.update_index   = '0;
    bus.global_correct = 1'b0;
    bus.local_correct  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until ready; expects exactly 64.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.ready && n < 200) begin
      step();
      n++;
    end
    chk(name, n, 64);
  endtask

  initial begin
    int exp_gw = 0;
    int exp_lw = 0;
    vecs[0]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd0,  1'b1, 2'd1};
    vecs[1]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd17, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd63, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 2'd1};
    vecs[4]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd5,  1'b1, 2'd2};
    vecs[5]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 6'd5,  1'b1, 2'd3};
    vecs[6]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 6'd5,  1'b1, 2'd3};
    vecs[7]  = '{1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 6'd5,  1'b1, 2'd2};
    vecs[8]  = '{1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 6'd5,  1'b1, 2'd1};
    vecs[9]  = '{1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 6'd5,  1'b1, 2'd0};
    vecs[10] = '{1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 6'd5,  1'b1, 2'd0};
    vecs[11] = '{1'b1, 6'd9,  1'b1, 1'b1, 1'b1, 6'd9,  1'b1, 2'd1};
    vecs[12] = '{1'b1, 6'd9,  1'b0, 1'b0, 1'b1, 6'd9,  1'b1, 2'd1};
    vecs[13] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd9,  1'b1, 2'd1};
    vecs[14] = '{1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 6'd12, 1'b1, 2'd2};
    vecs[15] = '{1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 6'd13, 1'b1, 2'd1};
    vecs[16] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd12, 1'b1, 2'd3};
    vecs[17] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd5,  1'b0, 2'd3};
    vecs[18] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 6'd5,  1'b1, 2'd0};

    idle_inputs();
    #12;
    chk("reset_ready", int'(bus.ready), 0);
    chk("reset_choice_valid", int'(bus.choice_valid), 0);
    chk("reset_choice_pred", int'(bus.choice_prediction), 0);
`ifdef TOURNAMENT_CHOICE_STATS_EN
    chk("reset_global_wins", int'(bus.global_wins), 0);
    chk("reset_local_wins", int'(bus.local_wins), 0);
`endif
    step();
    reset_n = 1'b1;
    wait_ready("init_sweep_cycles");

    foreach (vecs[i]) begin
      bus.update_valid   = vecs[i].upd_v;
      bus.update_index   = vecs[i].upd_idx;
      bus.global_correct = vecs[i].gc;
      bus.local_correct  = vecs[i].lc;
      bus.lookup_valid   = vecs[i].lk_v;
      bus.lookup_index   = vecs[i].lk_idx;
      if (vecs[i].upd_v && vecs[i].gc && !vecs[i].lc) exp_gw++;
      if (vecs[i].upd_v && !vecs[i].gc && vecs[i].lc) exp_lw++;
      step();
      chk($sformatf("vec%0d_valid", i), int'(bus.choice_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pred", i), int'(bus.choice_prediction), int'(vecs[i].exp_pred));
    end
    idle_inputs();

`ifdef TOURNAMENT_CHOICE_STATS_EN
    chk("stats_global_wins", int'(bus.global_wins), exp_gw);
    chk("stats_local_wins", int'(bus.local_wins), exp_lw);
`endif

    // Reset during RUN, then again 30 cycles into the sweep with traffic applied.
    reset_n = 1'b0;
    #2;
    chk("run_reset_ready", int'(bus.ready), 0);
    chk("run_reset_valid", int'(bus.choice_valid), 0);
`ifdef TOURNAMENT_CHOICE_STATS_EN
    chk("run_reset_global_wins", int'(bus.global_wins), 0);
    chk("run_reset_local_wins", int'(bus.local_wins), 0);
`endif
    step();
    reset_n = 1'b1;
    bus.lookup_valid   = 1'b1;
    bus.lookup_index   = 6'd17;
    bus.update_valid   = 1'b1;
    bus.update_index   = 6'd40;
    bus.global_correct = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      chk($sformatf("sweep_valid_c%0d", c), int'(bus.choice_valid), 0);
      chk($sformatf("sweep_ready_c%0d", c), int'(bus.ready), 0);
    end
`ifdef TOURNAMENT_CHOICE_STATS_EN
    chk("sweep_global_wins", int'(bus.global_wins), 0);
`endif
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    idle_inputs();
    wait_ready("resweep_cycles");

    // Entries modified before the resets are back at the init value.
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 6'd5;
    step();
    chk("resweep_idx5_valid", int'(bus.choice_valid), 1);
    chk("resweep_idx5_pred", int'(bus.choice_prediction), 1);
    bus.lookup_index = 6'd12;
    step();
    chk("resweep_idx12_pred", int'(bus.choice_prediction), 1);
    bus.lookup_index = 6'd40;
    step();
    chk("resweep_idx40_pred", int'(bus.choice_prediction), 1);

    // Back-to-back updates on index 33 without lookups, then read once.
    bus.lookup_valid   = 1'b0;
    bus.update_valid   = 1'b1;
    bus.update_index   = 6'd33;
    bus.global_correct = 1'b1;
    bus.local_correct  = 1'b0;
    step();
    step();
    bus.global_correct = 1'b0;
    bus.local_correct  = 1'b1;
    step();
    bus.update_valid = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 6'd33;
    step();
    chk("b2b_idx33_pred", int'(bus.choice_prediction), 2);
`ifdef TOURNAMENT_CHOICE_STATS_EN
    chk("b2b_global_wins", int'(bus.global_wins), 2);
    chk("b2b_local_wins", int'(bus.local_wins), 1);
`endif
    idle_inputs();
    step();
    chk("idle_valid", int'(bus.choice_valid), 0);
    chk("idle_pred_hold", int'(bus.choice_prediction), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
